// File: rtl/mac_tile.sv
// mac_tile: configurable routing tile holding four 8x8 multiply-accumulate units.
//
// A serial configuration chain is shifted in through shift_in/shift_out and
// copied into the active configuration when cset is asserted. The active
// configuration controls three things:
//   - the connection block (DCB), which gathers MAC operand bytes from the
//     north bus and drives MAC result bytes onto the south bus
//   - the switch block (DSB), which routes bus bits between the four sides
//   - the MAC mode and enable
// Loading a configuration also loads each accumulator with its init value.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   en                       MAC compute enable
//   cen, cset                config shift enable, latch chain into active config
//   shift_in, shift_out      config serial in and out (shift_out = chain bit 0)
//   cset_out                 combinational copy of cset, for daisy-chaining tiles
//   north/south/east/west    bidirectional routing buses; undriven bits are high-Z
module mac_tile #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 16,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int MAC_INT_WIDTH  = 40,
    parameter int DCB_NS_W       = 192,
    parameter int IX_IN_OUT_W    = 194,
    parameter int DCB_DATAIN     = 8,
    parameter int DCB_DATAOUT    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   cen,
    input  logic                   cset,
    input  logic                   shift_in,
    output logic                   shift_out,
    output logic                   cset_out,
    inout  wire  [IX_IN_OUT_W-1:0] north,
    inout  wire  [IX_IN_OUT_W-1:0] south,
    inout  wire  [IX_IN_OUT_W-1:0] east,
    inout  wire  [IX_IN_OUT_W-1:0] west
);

    localparam int NUM_MACS   = 4;
    localparam int DCB_W      = DCB_DATAIN + DCB_DATAOUT;
    localparam int DSB_BASE   = DCB_NS_W * DCB_W;
    localparam int INIT_BASE  = DSB_BASE + 6 * IX_IN_OUT_W;
    localparam int MODE_BASE  = INIT_BASE + NUM_MACS * MAC_ACC_WIDTH;
    localparam int TILE_BASE  = MODE_BASE + MAC_CONF_WIDTH;
    localparam int CONF_WIDTH = TILE_BASE + 2;
    localparam int WIRES_PER_BIT = DCB_NS_W / MAC_MIN_WIDTH;

    logic [CONF_WIDTH-1:0] chain_q, chain_d;
    logic [CONF_WIDTH-1:0] cfg_q, cfg_d;

    logic [DCB_DATAIN-1:0][MAC_MIN_WIDTH-1:0]  in_byte;
    logic [NUM_MACS-1:0][MAC_ACC_WIDTH-1:0]    acc_all;
    logic [DCB_DATAOUT-1:0][MAC_MIN_WIDTH-1:0] out_byte;
    logic [IX_IN_OUT_W-1:0]                    dcb_oe;
    logic [IX_IN_OUT_W-1:0]                    dcb_val;

    logic tile_mac_en, tile_dcb_en, mode_signed, mode_acc;
    logic cfg_unused;

    assign tile_mac_en = cfg_q[TILE_BASE];
    assign tile_dcb_en = cfg_q[TILE_BASE + 1];
    assign mode_signed = cfg_q[MODE_BASE];
    assign mode_acc    = cfg_q[MODE_BASE + 1];

    // Init values are consumed straight from the chain at latch time, and the
    // upper mode bits have no function, so these active-config bits are never read.
    assign cfg_unused = ^{cfg_q[INIT_BASE +: NUM_MACS * MAC_ACC_WIDTH],
                          cfg_q[MODE_BASE + 2 +: MAC_CONF_WIDTH - 2]};

    assign shift_out = chain_q[0];
    assign cset_out  = cset;
    assign out_byte  = acc_all;

    // Configuration state: chain and active config
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
            cfg_q   <= '0;
        end else begin
            chain_q <= chain_d;
            cfg_q   <= cfg_d;
        end
    end

    // The latch copies the chain as it was before this edge's shift.
    always_comb begin
        chain_d = chain_q;
        cfg_d   = cfg_q;
        if (cen) begin
            chain_d = {shift_in, chain_q[CONF_WIDTH-1:1]};
        end
        if (cset) begin
            cfg_d = chain_q;
        end
    end

    // Input byte k, bit b collects every north wire w with w%8==b whose cin[w][k] is set.
    for (genvar k = 0; k < DCB_DATAIN; k++) begin : g_in_k
        for (genvar b = 0; b < MAC_MIN_WIDTH; b++) begin : g_in_b
            logic [WIRES_PER_BIT-1:0] terms;
            for (genvar j = 0; j < WIRES_PER_BIT; j++) begin : g_term
                assign terms[j] = north[j*MAC_MIN_WIDTH + b]
                                & cfg_q[(j*MAC_MIN_WIDTH + b)*DCB_W + k];
            end
            assign in_byte[k][b] = |terms;
        end
    end

    // South wire w carries bit w%8 of every output byte selected by its cout field.
    for (genvar w = 0; w < DCB_NS_W; w++) begin : g_dcb
        logic [DCB_DATAOUT-1:0] cout;
        logic [DCB_DATAOUT-1:0] hits;
        assign cout = cfg_q[w*DCB_W + DCB_DATAIN +: DCB_DATAOUT];
        for (genvar m = 0; m < DCB_DATAOUT; m++) begin : g_hit
            assign hits[m] = cout[m] & out_byte[m][w % MAC_MIN_WIDTH];
        end
        assign dcb_oe[w]  = tile_dcb_en & (|cout);
        assign dcb_val[w] = |hits;
    end
    for (genvar w = DCB_NS_W; w < IX_IN_OUT_W; w++) begin : g_dcb_none
        assign dcb_oe[w]  = 1'b0;
        assign dcb_val[w] = 1'b0;
    end

    // Switch block: each destination bit is the OR of its enabled sources.
    // S->N yields to N->S and E->W yields to W->E so a bit never loops back on itself.
    for (genvar i = 0; i < IX_IN_OUT_W; i++) begin : g_bus
        logic [5:0] dsb;
        logic       n_oe, s_oe, e_oe, w_oe;
        assign dsb  = cfg_q[DSB_BASE + 6*i +: 6];
        assign n_oe = dsb[1] & ~dsb[0];
        assign s_oe = dsb[0] | dsb[5] | dcb_oe[i];
        assign e_oe = dsb[3] | dsb[4];
        assign w_oe = dsb[2] & ~dsb[3];
        assign north[i] = n_oe ? south[i] : 1'bz;
        assign south[i] = s_oe ? ((dsb[0] & north[i]) | (dsb[5] & west[i])
                                  | (dcb_oe[i] & dcb_val[i])) : 1'bz;
        assign east[i]  = e_oe ? ((dsb[3] & west[i]) | (dsb[4] & north[i])) : 1'bz;
        assign west[i]  = w_oe ? east[i] : 1'bz;
    end

    // MAC i multiplies input bytes 2i and 2i+1; the sum is formed at the wide
    // internal width and wrapped back to the accumulator width.
    for (genvar i = 0; i < NUM_MACS; i++) begin : g_mac
        logic [MAC_ACC_WIDTH-1:0]  acc_q, acc_d;
        logic [MAC_MIN_WIDTH-1:0]  op_a, op_b;
        logic [MAC_MULT_WIDTH-1:0] prod;
        logic [MAC_INT_WIDTH-1:0]  prod_ext;

        assign op_a       = in_byte[2*i];
        assign op_b       = in_byte[2*i + 1];
        assign acc_all[i] = acc_q;

        // Product and its extension to the internal width, per signedness mode
        always_comb begin
            prod     = '0;
            prod_ext = '0;
            if (mode_signed) begin
                prod     = MAC_MULT_WIDTH'($signed(op_a)) * MAC_MULT_WIDTH'($signed(op_b));
                prod_ext = MAC_INT_WIDTH'($signed(prod));
            end else begin
                prod     = MAC_MULT_WIDTH'(op_a) * MAC_MULT_WIDTH'(op_b);
                prod_ext = MAC_INT_WIDTH'(prod);
            end
        end

        // A config latch reloads the init value and wins over compute.
        always_comb begin
            acc_d = acc_q;
            if (cset) begin
                acc_d = chain_q[INIT_BASE + i*MAC_ACC_WIDTH +: MAC_ACC_WIDTH];
            end else if (en && tile_mac_en) begin
                if (mode_acc) begin
                    acc_d = MAC_ACC_WIDTH'(MAC_INT_WIDTH'(acc_q) + prod_ext);
                end else begin
                    acc_d = MAC_ACC_WIDTH'(prod_ext);
                end
            end
        end

        // Accumulator register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

endmodule

// File: tb/tb_mac_tile.sv
// tb_mac_tile: self-checking bench for mac_tile.
// Configurations are described as small records (mode, W->E switching,
// accumulator inits) and expanded into chain bits; operand bytes are routed
// straight from north bytes and all accumulator bytes are exposed on
// south[127:0], so expected bus values come from a plain arithmetic MAC model.
`timescale 1ns/1ps
module tb_mac_tile;

    localparam int IXW       = 194;
    localparam int NSW       = 192;
    localparam int CW        = 192*(8+16) + 6*194 + 4*32 + 4 + 2;
    localparam int DSB_BASE  = NSW * 24;
    localparam int INIT_BASE = DSB_BASE + 6*IXW;
    localparam int MODE_BASE = INIT_BASE + 4*32;
    localparam int TILE_BASE = MODE_BASE + 4;

    typedef struct packed {
        logic [1:0]        mode;
        logic              we;
        logic [3:0][31:0]  inits;
    } cfg_t;

    logic clk = 1'b0;
    logic rst, en, cen, cset, shift_in;
    wire  shift_out, cset_out;
    wire  [IXW-1:0] north, south, east, west;
    logic [IXW-1:0] north_drv, west_drv;

    assign north = north_drv;
    assign west  = west_drv;

    int n_checks;
    int n_fail;

    logic [CW-1:0]     chain_m;
    logic [3:0][31:0]  acc_m;
    cfg_t              pend, act;
    bit                pend_valid, act_valid;
    logic [IXW-1:0]    allz;

    mac_tile dut (
        .clk(clk), .rst(rst), .en(en), .cen(cen), .cset(cset),
        .shift_in(shift_in), .shift_out(shift_out), .cset_out(cset_out),
        .north(north), .south(south), .east(east), .west(west)
    );

    always #5 clk = ~clk;

    function automatic logic [IXW-1:0] rand_bus();
        logic [IXW-1:0] r;
        for (int i = 0; i < IXW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Byte k of the MAC inputs is north byte k; output byte m lands on south byte m.
    function automatic logic [CW-1:0] build_cfg(input cfg_t d);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < 8; k++)
            for (int b = 0; b < 8; b++) c[(8*k + b)*24 + k] = 1'b1;
        for (int m = 0; m < 16; m++)
            for (int b = 0; b < 8; b++) c[(8*m + b)*24 + 8 + m] = 1'b1;
        if (d.we)
            for (int i = 0; i < IXW; i++) c[DSB_BASE + 6*i + 3] = 1'b1;
        for (int i = 0; i < 4; i++) c[INIT_BASE + 32*i +: 32] = d.inits[i];
        c[MODE_BASE +: 2] = d.mode;
        c[TILE_BASE]      = 1'b1;
        c[TILE_BASE + 1]  = 1'b1;
        return c;
    endfunction

    function automatic logic [IXW-1:0] exp_south();
        logic [IXW-1:0] e;
        e = {IXW{1'bz}};
        if (act_valid) e[127:0] = acc_m;
        return e;
    endfunction

    function automatic logic [IXW-1:0] exp_east();
        return (act_valid && act.we) ? west_drv : {IXW{1'bz}};
    endfunction

    task automatic check_bus(input string tag, input logic [IXW-1:0] obs, input logic [IXW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Shift a full configuration in; the old chain must stream out first bit first.
    task automatic load_chain(input cfg_t d);
        logic [CW-1:0] bits;
        bits = build_cfg(d);
        for (int j = 0; j < CW; j++) begin
            cen      = 1'b1;
            shift_in = bits[j];
            check_bit("shift_out_stream", shift_out, chain_m[j]);
            @(posedge clk); #1;
        end
        cen        = 1'b0;
        chain_m    = bits;
        pend       = d;
        pend_valid = 1'b1;
    endtask

    task automatic do_cset(input bit with_en);
        cset = 1'b1;
        en   = with_en;
        @(posedge clk); #1;
        cset      = 1'b0;
        en        = 1'b0;
        act       = pend;
        act_valid = pend_valid;
        acc_m     = pend_valid ? pend.inits : '0;
        check_bus("cset_south", south, exp_south());
    endtask

    task automatic mac_step(input logic [IXW-1:0] nval, input bit en_v);
        north_drv = nval;
        en        = en_v;
        @(posedge clk); #1;
        en = 1'b0;
        if (en_v && act_valid) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] a, b;
                longint     p;
                a = nval[16*i +: 8];
                b = nval[16*i + 8 +: 8];
                if (act.mode[0]) p = longint'($signed(a)) * longint'($signed(b));
                else             p = longint'(a) * longint'(b);
                acc_m[i] = act.mode[1] ? acc_m[i] + 32'(p) : 32'(p);
            end
        end
        check_bus("mac_south", south, exp_south());
    endtask

    initial begin
        cfg_t           d_a, d_b, d_c;
        logic [IXW-1:0] nval;

        n_checks = 0;
        n_fail   = 0;
        allz     = {IXW{1'bz}};
        rst = 1'b1; en = 1'b0; cen = 1'b0; cset = 1'b0; shift_in = 1'b0;
        north_drv = rand_bus();
        west_drv  = rand_bus();
        chain_m = '0; acc_m = '0; pend = '0; act = '0;
        pend_valid = 1'b0; act_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_shift_out", shift_out, 1'b0);
        check_bus("rst_south", south, allz);
        check_bus("rst_east", east, allz);
        check_bus("rst_north", north, north_drv);
        cset = 1'b1; #1;
        check_bit("cset_out_hi", cset_out, 1'b1);
        cset = 1'b0; #1;
        check_bit("cset_out_lo", cset_out, 1'b0);
        rst = 1'b0;

        d_a = '0; d_a.mode = 2'b10; d_a.we = 1'b1;
        d_b = '0; d_b.mode = 2'b11;
        d_c = '0; d_c.mode = 2'b10;
        d_c.inits[0] = 32'hFFFF_FFFF;
        for (int i = 1; i < 4; i++) d_c.inits[i] = $urandom();

        $display("[TB] shifting without latch");
        load_chain(d_b);
        west_drv = rand_bus(); #1;
        check_bus("noset_south", south, allz);
        check_bus("noset_east", east, allz);

        $display("[TB] unsigned accumulate with W->E routing");
        load_chain(d_a);
        do_cset(1'b0);
        for (int i = 0; i < 4; i++) begin
            west_drv = rand_bus(); #1;
            check_bus("we_east", east, exp_east());
        end
        nval = rand_bus();
        nval[15:0] = 16'h0302;
        for (int s = 1; s <= 3; s++) begin
            mac_step(nval, 1'b1);
            check_word("acc0_3x2", south[31:0], 32'(6*s));
        end
        mac_step(rand_bus(), 1'b0);
        do_cset(1'b1);
        nval[15:0] = 16'h02FF;
        mac_step(nval, 1'b1);
        check_word("acc0_uns_1", south[31:0], 32'h0000_01FE);
        mac_step(nval, 1'b1);
        check_word("acc0_uns_2", south[31:0], 32'h0000_03FC);
        for (int i = 0; i < 10; i++) mac_step(rand_bus(), 1'($urandom_range(0, 1)));

        $display("[TB] signed accumulate");
        load_chain(d_b);
        do_cset(1'b0);
        west_drv = rand_bus(); #1;
        check_bus("cleared_east", east, exp_east());
        nval = rand_bus();
        nval[15:0] = 16'h02FF;
        mac_step(nval, 1'b1);
        check_word("acc0_sgn_1", south[31:0], 32'hFFFF_FFFE);
        mac_step(nval, 1'b1);
        check_word("acc0_sgn_2", south[31:0], 32'hFFFF_FFFC);
        for (int i = 0; i < 10; i++) mac_step(rand_bus(), 1'($urandom_range(0, 1)));

        $display("[TB] init load and wrap");
        load_chain(d_c);
        do_cset(1'b1);
        nval = rand_bus();
        nval[15:0] = 16'h0101;
        mac_step(nval, 1'b1);
        check_word("acc0_wrap", south[31:0], 32'h0000_0000);
        for (int i = 0; i < 10; i++) mac_step(rand_bus(), 1'($urandom_range(0, 1)));

        $display("[TB] connection block drive and async reset");
        do_cset(1'b0);
        check_bit("dcb_south0", south[0], 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_bus("async_rst_south", south, allz);
        check_bus("async_rst_east", east, allz);
        check_bit("async_rst_shift_out", shift_out, 1'b0);
        chain_m = '0; acc_m = '0; pend_valid = 1'b0; act_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_cset(1'b0);
        check_bus("post_rst_east", east, allz);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
